// File: rtl/truth_table_checker_if.sv
// Bundle between truth_table_checker and the block that uses it.
// master: the side that issues start, returns the outputs of the two
//         implementations under check and reads the verdict.
// slave : the checker. It drives the vectors and the results.
// Signals: start, vec_out[N_IN], y_a, y_b, busy, done, pass,
//          mismatch_count[N_IN+1], first_fail[N_IN], table_a/table_b[2^N_IN]
interface truth_table_checker_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic [N_IN-1:0]      vec_out;
  logic                 y_a;
  logic                 y_b;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        mismatch_count;
  logic [N_IN-1:0]      first_fail;
  logic [2**N_IN-1:0]   table_a;
  logic [2**N_IN-1:0]   table_b;

  modport master (
    output start, y_a, y_b,
    input  vec_out, busy, done, pass, mismatch_count, first_fail, table_a, table_b
  );

  modport slave (
    input  start, y_a, y_b,
    output vec_out, busy, done, pass, mismatch_count, first_fail, table_a, table_b
  );
endinterface

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all 2^N_IN input vectors onto two combinational
// implementations. It holds each vector for SETTLE_CYCLES cycles and then
// samples both outputs. It captures both truth tables and reports whether the
// two are equivalent, the mismatch count and the lowest failing vector.
// Ports: clk, rst_n (async, active low), bus (truth_table_checker_if.slave).
// Optional macro TT_CHECKER_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module truth_table_checker #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_checker_if.slave   bus
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [N_IN-1:0]     vec_q;
  logic [N_IN:0]       count_q;
  logic [N_IN-1:0]     ff_q;
  logic [2**N_IN-1:0]  ta_q, tb_q;
  logic                pass_q;
  logic                mism, last_vec, stop_hit;

  assign mism     = bus.y_a ^ bus.y_b;
  assign last_vec = &vec_q;
`ifdef TT_CHECKER_STOP_ON_FAIL_EN
  assign stop_hit = mism;
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = SETTLE;
      SETTLE:     if (cnt_q == CNT_LAST) state_d = SAMPLE;
      SAMPLE:     state_d = (last_vec || stop_hit) ? DONE : SETTLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == SETTLE) || (state_q == SAMPLE);
    bus.done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      vec_q   <= '0;
      count_q <= '0;
      ff_q    <= '0;
      ta_q    <= '0;
      tb_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            cnt_q   <= '0;
            vec_q   <= '0;
            count_q <= '0;
            ff_q    <= '0;
            ta_q    <= '0;
            tb_q    <= '0;
            pass_q  <= 1'b0;
          end
        end
        SETTLE: cnt_q <= cnt_q + 1'b1;
        SAMPLE: begin
          ta_q[vec_q] <= bus.y_a;
          tb_q[vec_q] <= bus.y_b;
          if (mism) begin
            count_q <= count_q + 1'b1;
            // Sweep runs in ascending order, so the first mismatch is the lowest.
            if (count_q == '0) ff_q <= vec_q;
          end
          if (last_vec || stop_hit) begin
            pass_q <= (count_q == '0) && !mism;
          end else begin
            vec_q <= vec_q + 1'b1;
            cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.vec_out        = vec_q;
  assign bus.mismatch_count = count_q;
  assign bus.first_fail     = ff_q;
  assign bus.table_a        = ta_q;
  assign bus.table_b        = tb_q;
  assign bus.pass           = pass_q;
endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_d = 1'b0;
  logic sel = 1'b0;            // 0: dut1 (SETTLE_CYCLES=1), 1: dut3 (SETTLE_CYCLES=3)
  logic [7:0] tt_a = '0, tt_b = '0;
  int vectors = 0, fails = 0;

  always #5 clk = ~clk;

  truth_table_checker_if #(.N_IN(3)) b1 ();
  truth_table_checker_if #(.N_IN(3)) b3 ();

  truth_table_checker #(.N_IN(3), .SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  truth_table_checker #(.N_IN(3), .SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  assign b1.start = start_d & ~sel;
  assign b3.start = start_d & sel;
  assign b1.y_a = tt_a[b1.vec_out];
  assign b1.y_b = tt_b[b1.vec_out];
  assign b3.y_a = tt_a[b3.vec_out];
  assign b3.y_b = tt_b[b3.vec_out];

  logic [2:0] m_vec, m_ff;
  logic [3:0] m_cnt;
  logic [7:0] m_ta, m_tb;
  logic m_busy, m_done, m_pass;
  always_comb begin
    m_vec  = sel ? b3.vec_out        : b1.vec_out;
    m_ff   = sel ? b3.first_fail     : b1.first_fail;
    m_cnt  = sel ? b3.mismatch_count : b1.mismatch_count;
    m_ta   = sel ? b3.table_a        : b1.table_a;
    m_tb   = sel ? b3.table_b        : b1.table_b;
    m_busy = sel ? b3.busy           : b1.busy;
    m_done = sel ? b3.done           : b1.done;
    m_pass = sel ? b3.pass           : b1.pass;
  end

  typedef struct {
    logic [7:0] tt_a, tt_b;
    logic       pass;
    logic [3:0] cnt;
    logic [2:0] ff;
  } vec_t;

  typedef struct {
    logic       pass;
    logic [3:0] cnt;
    logic [2:0] ff, vec;
    logic [7:0] ta, tb;
    int         edges;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic exp_t make_exp(input vec_t v, input int sc);
    exp_t e;
    logic [8:0] mask;
    e.pass = v.pass; e.cnt = v.cnt; e.ff = v.ff;
    e.ta = v.tt_a; e.tb = v.tt_b; e.vec = 3'd7; e.edges = 8 * (sc + 1);
    mask = '1;
`ifdef TT_CHECKER_STOP_ON_FAIL_EN
    if (v.cnt != 0) begin
      mask = (9'd1 << (v.ff + 1)) - 9'd1;
      e.cnt = 4'd1; e.vec = v.ff; e.edges = (v.ff + 1) * (sc + 1);
      e.ta = v.tt_a & mask[7:0]; e.tb = v.tt_b & mask[7:0];
    end
`endif
    return e;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_vec1"},  {29'd0, b1.vec_out}, 0);
    chk({tag, "_busy1"}, {31'd0, b1.busy}, 0);
    chk({tag, "_done1"}, {31'd0, b1.done}, 0);
    chk({tag, "_pass1"}, {31'd0, b1.pass}, 0);
    chk({tag, "_cnt1"},  {28'd0, b1.mismatch_count}, 0);
    chk({tag, "_ff1"},   {29'd0, b1.first_fail}, 0);
    chk({tag, "_ta1"},   {24'd0, b1.table_a}, 0);
    chk({tag, "_tb1"},   {24'd0, b1.table_b}, 0);
    chk({tag, "_busy3"}, {31'd0, b3.busy}, 0);
    chk({tag, "_done3"}, {31'd0, b3.done}, 0);
    chk({tag, "_vec3"},  {29'd0, b3.vec_out}, 0);
  endtask

  // Pulse start (sampled on edge 0), then count edges to done.
  task automatic run_sweep(input logic s, input vec_t v, input bit restart_mid);
    int n, sc;
    exp_t e;
    sel = s; sc = s ? 3 : 1;
    tt_a = v.tt_a; tt_b = v.tt_b;
    sb.push_back(make_exp(v, sc));
    @(negedge clk) start_d = 1'b1;
    @(negedge clk) start_d = 1'b0;
    chk("busy_after_start", {31'd0, m_busy}, 1);
    chk("done_after_start", {31'd0, m_done}, 0);
    chk("cleared_cnt", {28'd0, m_cnt}, 0);
    chk("cleared_tables", {16'd0, m_ta, m_tb}, 0);
    chk("vec_start", {29'd0, m_vec}, 0);
    n = 0;
    while (!m_done && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      start_d = 1'b0;
      chk("busy_done_excl", {31'd0, m_busy & m_done}, 0);
      if (!m_done && (n % (sc + 1)) == 0)
        chk("vec_step", {29'd0, m_vec}, n / (sc + 1));
      if (restart_mid && n == 10) start_d = 1'b1;
    end
    start_d = 1'b0;
    chk("sb_nonempty", sb.size(), 1);
    e = sb.pop_front();
    chk("done_edges", n, e.edges);
    chk("done_level", {31'd0, m_done}, 1);
    chk("busy_at_done", {31'd0, m_busy}, 0);
    chk("pass", {31'd0, m_pass}, {31'd0, e.pass});
    chk("mismatch_count", {28'd0, m_cnt}, {28'd0, e.cnt});
    chk("first_fail", {29'd0, m_ff}, {29'd0, e.ff});
    chk("vec_at_done", {29'd0, m_vec}, {29'd0, e.vec});
    chk("table_a", {24'd0, m_ta}, {24'd0, e.ta});
    chk("table_b", {24'd0, m_tb}, {24'd0, e.tb});
    @(negedge clk);
    chk("done_held", {31'd0, m_done}, 1);
  endtask

  vec_t tbl[8];

  initial begin
    int n;
    tbl[0] = '{8'hEA, 8'hEA, 1'b1, 4'd0, 3'd0};   // (A&B)|C on both
    tbl[1] = '{8'hEA, 8'hCA, 1'b0, 4'd1, 3'd5};   // single-minterm fault at 5
    tbl[2] = '{8'h00, 8'hFF, 1'b0, 4'd8, 3'd0};   // every vector differs
    tbl[3] = '{8'h0F, 8'h1F, 1'b0, 4'd1, 3'd4};
    tbl[4] = '{8'h81, 8'h80, 1'b0, 4'd1, 3'd0};   // fail at vector 0
    tbl[5] = '{8'h3C, 8'hFC, 1'b0, 4'd2, 3'd6};
    tbl[6] = '{8'hA5, 8'hDB, 1'b0, 4'd6, 3'd1};
    tbl[7] = '{8'h44, 8'h00, 1'b0, 4'd2, 3'd2};   // mismatches at 2 and 6

    #12;
    check_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_reset("idle");

    for (int i = 0; i < 8; i++) run_sweep(1'b0, tbl[i], 1'b0);

    // Longer settle with a start re-pulsed mid-sweep.
    run_sweep(1'b1, tbl[1], 1'b1);
    run_sweep(1'b1, tbl[0], 1'b0);

    // Reset while vec_out is 4, then a clean sweep.
    sel = 1'b0; tt_a = 8'hEA; tt_b = 8'hEA;
    @(negedge clk) start_d = 1'b1;
    @(negedge clk) start_d = 1'b0;
    n = 0;
    while (b1.vec_out != 3'd4 && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("reach_vec4", {29'd0, b1.vec_out}, 4);
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    @(negedge clk) rst_n = 1'b1;
    run_sweep(1'b0, tbl[1], 1'b0);
    run_sweep(1'b0, tbl[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Sequential response checker for the digital-electronics lab designs. It sweeps every input combination onto two combinational implementations of the same function, such as a two-level and a three-level minimization, and waits a programmable settle time per vector. It then samples both outputs, builds each function's truth table and reports equivalence, mismatch count and first failing vector. It replaces per-vector manual waveform inspection: the bench or top level issues `start` and reads a verdict.

## Interface
Parameters:
- `N_IN`, 3: number of function inputs; vector width. Range 1–6.
- `SETTLE_CYCLES`, 1: cycles each vector is held before sampling. Minimum 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sweep. Honoured only in IDLE or DONE.
- `vec_out`  out  N_IN  drives the inputs of both designs under check; bit N_IN-1 is the MSB (A for N_IN=3).
- `y_a`  in  1  output of implementation A.
- `y_b`  in  1  output of implementation B.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  level; high in DONE until the next accepted `start` or reset.
- `pass`  out  1  valid while `done`; 1 when no mismatches were found.
- `mismatch_count`  out  N_IN+1  number of vectors where `y_a` != `y_b`.
- `first_fail`  out  N_IN  lowest-index mismatching vector; 0 when `pass`=1.
- `table_a`  out  2^N_IN  captured truth table of `y_a`; bit i corresponds to vector i.
- `table_b`  out  2^N_IN  captured truth table of `y_b`.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + `start`:
  - `vec_out`<=0, settle counter<=0.
  - `table_a`, `table_b`, `mismatch_count`, `first_fail` <= 0; `pass`<=0, `done`<=0.
  - Next state SETTLE.
- SETTLE:
  - settle counter increments each cycle.
  - When counter == SETTLE_CYCLES-1, go to SAMPLE.
  - `vec_out` stable throughout.
- SAMPLE (exactly one cycle):
  - `table_a[vec_out]`<=`y_a`, `table_b[vec_out]`<=`y_b`.
  - On mismatch: `mismatch_count`++; if it is the first mismatch, `first_fail`<=`vec_out`.
  - If `vec_out` == 2^N_IN-1: go to DONE with `pass` <= (final count == 0).
  - Otherwise `vec_out`++, counter<=0, go to SETTLE.
- DONE: all results held. `vec_out` holds its last value.
- `start` while `busy` is ignored and has no effect on the sweep.
- `mismatch_count` cannot overflow: its width holds 2^N_IN.
- `y_a` and `y_b` are sampled only in SAMPLE; values in any other state are don't-care.

## Timing
- Reset values, applied asynchronously on `rst_n` low: state IDLE, `vec_out`=0, `busy`=0, `done`=0, `pass`=0, `mismatch_count`=0, `first_fail`=0, `table_a`=0, `table_b`=0.
- Reset mid-sweep aborts immediately to the reset values. No partial results are retained.
- `start` is sampled on edge 0 and `busy` rises after edge 0.
- Each vector takes SETTLE_CYCLES+1 edges.
- `done` rises after edge 2^N_IN*(SETTLE_CYCLES+1). Example: N_IN=3, SETTLE_CYCLES=1 gives `done` after edge 16.
- `busy` and `done` are never high together.
- `start` arriving in the same cycle `done` rises is ignored: the state is still SAMPLE.

## Configuration
- Macro: `TT_CHECKER_STOP_ON_FAIL_EN`.
- Defined: on the first mismatch, SAMPLE goes directly to DONE with `pass`=0 and `mismatch_count`=1. `vec_out` and `first_fail` equal the failing vector, and table bits above that vector remain 0.
- Undefined (default): the full sweep always runs and counts every mismatch.

## Test plan
- **Equivalent pair.** `y_a`=`y_b`=(A&B)|C, N_IN=3, SETTLE_CYCLES=1, pulse `start` → `done` after 16 edges; `pass`=1, `mismatch_count`=0, `table_a`=`table_b`=8'hEA.
- **Single-minterm fault.** `y_b` differs from `y_a` only at vector 5 → `pass`=0, `mismatch_count`=1, `first_fail`=5, `table_a`^`table_b`=8'h20.
- **Settle and ignored start.** SETTLE_CYCLES=3, `start` re-pulsed while `busy` → `vec_out` steps every 4 cycles; `done` after 32 edges; the second `start` has no effect.
- **Reset mid-sweep, then restart.** `rst_n` low when `vec_out`=4 → all outputs return to reset values immediately. A new `start` then completes a clean sweep from vector 0.
- **Stop-on-fail.** `TT_CHECKER_STOP_ON_FAIL_EN` defined, mismatches at vectors 2 and 6 → `done` after 6 edges; `first_fail`=2, `mismatch_count`=1, `vec_out`=2.
- **Restart from DONE.** `start` pulsed while in DONE → results clear and a new sweep begins; `done` low the cycle after `start`.
